// File: rtl/bldc_commutation_controller.sv
// Six-step trapezoidal BLDC commutation controller: Hall synchronizer, dead-time
// sequencing between gate patterns and PWM on the active high-side switch.
module bldc_commutation_controller #(
    parameter int unsigned DEAD_CYCLES = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       dir,
    input  logic [7:0] duty,
    input  logic [2:0] hall,
    output logic       HA,
    output logic       HB,
    output logic       HC,
    output logic       LA,
    output logic       LB,
    output logic       LC,
    output logic       fault,
    output logic       comm_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DEAD  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // The counter expires on the DEAD_CYCLES-th clock after loading.
    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES - 1);

    function automatic logic hall_legal(input logic [2:0] code);
        hall_legal = (code != 3'b000) && (code != 3'b111);
    endfunction

    // Returns {high phase, low phase}, each one-hot in {A,B,C} order.
    function automatic logic [5:0] phase_map(input logic [2:0] code, input logic rev);
        logic [2:0] hi;
        logic [2:0] lo;
        case (code)
            3'b101:  begin hi = 3'b100; lo = 3'b010; end
            3'b100:  begin hi = 3'b100; lo = 3'b001; end
            3'b110:  begin hi = 3'b010; lo = 3'b001; end
            3'b010:  begin hi = 3'b010; lo = 3'b100; end
            3'b011:  begin hi = 3'b001; lo = 3'b100; end
            3'b001:  begin hi = 3'b001; lo = 3'b010; end
            default: begin hi = 3'b000; lo = 3'b000; end
        endcase
        if (rev) begin
            phase_map = {lo, hi};
        end else begin
            phase_map = {hi, lo};
        end
    endfunction

    logic [2:0] hall_meta_r;
    logic [2:0] hall_sync_r;
    state_t     state_r;
    state_t     next_state_s;
    logic [2:0] hall_q_r;
    logic       dir_q_r;
    logic [7:0] dead_cnt_r;
    logic [7:0] pwm_cnt_r;
    logic [2:0] next_hall_q_s;
    logic       next_dir_q_s;
    logic [7:0] next_dead_s;
    logic       legal_s;
    logic       change_s;
    logic [5:0] pattern_s;
    logic       pwm_on_s;
    logic [2:0] gate_hi_s;
    logic [2:0] gate_lo_s;
    logic [2:0] gate_hi_r;
    logic [2:0] gate_lo_r;
    logic       fault_r;
    logic       comm_pulse_r;

    assign legal_s  = hall_legal(hall_sync_r);
    assign change_s = (hall_sync_r != hall_q_r) || (dir != dir_q_r);

    // Two-flop synchronizer for the asynchronous Hall inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hall_meta_r <= 3'b000;
            hall_sync_r <= 3'b000;
        end else begin
            hall_meta_r <= hall;
            hall_sync_r <= hall_meta_r;
        end
    end

    // Next-state, latch and dead-counter decisions.
    always_comb begin
        next_state_s  = state_r;
        next_hall_q_s = hall_q_r;
        next_dir_q_s  = dir_q_r;
        next_dead_s   = dead_cnt_r;
        if (!enable) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (legal_s) begin
                        next_state_s  = ST_DEAD;
                        next_hall_q_s = hall_sync_r;
                        next_dir_q_s  = dir;
                        next_dead_s   = DEAD_LOAD;
                    end else begin
                        next_state_s = ST_FAULT;
                    end
                end
                ST_DEAD: begin
                    if (!legal_s) begin
                        next_state_s = ST_FAULT;
                    end else if (change_s) begin
                        next_hall_q_s = hall_sync_r;
                        next_dir_q_s  = dir;
                        next_dead_s   = DEAD_LOAD;
                    end else if (dead_cnt_r == 8'd0) begin
                        next_state_s = ST_DRIVE;
                    end else begin
                        next_dead_s = dead_cnt_r - 8'd1;
                    end
                end
                ST_DRIVE: begin
                    if (!legal_s) begin
                        next_state_s = ST_FAULT;
                    end else if (change_s) begin
                        next_state_s  = ST_DEAD;
                        next_hall_q_s = hall_sync_r;
                        next_dir_q_s  = dir;
                        next_dead_s   = DEAD_LOAD;
                    end else begin
                        next_state_s = ST_DRIVE;
                    end
                end
                ST_FAULT: next_state_s = ST_FAULT;
                default:  next_state_s = ST_IDLE;
            endcase
        end
    end

    // Gate pattern for the coming cycle; nonzero only when entering or staying in DRIVE.
    always_comb begin
        pattern_s = phase_map(next_hall_q_s, next_dir_q_s);
        pwm_on_s  = (pwm_cnt_r < duty);
        gate_hi_s = 3'b000;
        gate_lo_s = 3'b000;
        if (next_state_s == ST_DRIVE) begin
            gate_hi_s = pattern_s[5:3] & {3{pwm_on_s}};
            gate_lo_s = pattern_s[2:0];
        end else begin
            gate_hi_s = 3'b000;
            gate_lo_s = 3'b000;
        end
    end

    // State, applied Hall code, dead-time and PWM counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            hall_q_r   <= 3'b000;
            dir_q_r    <= 1'b0;
            dead_cnt_r <= 8'd0;
            pwm_cnt_r  <= 8'd0;
        end else begin
            state_r    <= next_state_s;
            hall_q_r   <= next_hall_q_s;
            dir_q_r    <= next_dir_q_s;
            dead_cnt_r <= next_dead_s;
            pwm_cnt_r  <= pwm_cnt_r + 8'd1;
        end
    end

    // Registered gate, fault and commutation-pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_hi_r    <= 3'b000;
            gate_lo_r    <= 3'b000;
            fault_r      <= 1'b0;
            comm_pulse_r <= 1'b0;
        end else begin
            gate_hi_r    <= gate_hi_s;
            gate_lo_r    <= gate_lo_s;
            fault_r      <= (next_state_s == ST_FAULT);
            comm_pulse_r <= (state_r == ST_DEAD) && (next_state_s == ST_DRIVE);
        end
    end

    assign HA         = gate_hi_r[2];
    assign HB         = gate_hi_r[1];
    assign HC         = gate_hi_r[0];
    assign LA         = gate_lo_r[2];
    assign LB         = gate_lo_r[1];
    assign LC         = gate_lo_r[0];
    assign fault      = fault_r;
    assign comm_pulse = comm_pulse_r;

endmodule

// File: tb/tb_bldc_commutation_controller.sv
// Directed bench for bldc_commutation_controller: a run-length behavioural model
// checked every cycle, plus hand-computed dead-time, latency and duty expectations.
module tb_bldc_commutation_controller;

    localparam int D = 50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       dir;
    logic [7:0] duty;
    logic [2:0] hall;
    logic       HA, HB, HC, LA, LB, LC, fault, comm_pulse;
    logic [5:0] g;

    int checks = 0;
    int failures = 0;
    int pulse_count = 0;

    // Model state: Hall samples, run length of stable legal inputs, fault flag.
    logic [2:0] m_s1, m_s2, m_ph, m_hs;
    logic       m_pd, m_flt, m_pulse;
    logic [5:0] m_g;
    int         m_run, m_edges;

    logic [2:0] steps [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    logic [5:0] exp_hi [6] = '{6'b100000, 6'b010000, 6'b010000, 6'b001000, 6'b001000, 6'b100000};
    logic [5:0] exp_lo [6] = '{6'b000001, 6'b000001, 6'b000100, 6'b000100, 6'b000010, 6'b000010};

    assign g = {HA, HB, HC, LA, LB, LC};

    bldc_commutation_controller #(.DEAD_CYCLES(D)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .dir(dir), .duty(duty), .hall(hall),
        .HA(HA), .HB(HB), .HC(HC), .LA(LA), .LB(LB), .LC(LC),
        .fault(fault), .comm_pulse(comm_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Commutation table by phase index (0=A, 1=B, 2=C); reverse swaps high and low.
    function automatic logic [5:0] table_pat(input logic [2:0] h, input logic d);
        int hi, lo, t;
        case (h)
            3'd5: begin hi = 0; lo = 1; end
            3'd4: begin hi = 0; lo = 2; end
            3'd6: begin hi = 1; lo = 2; end
            3'd2: begin hi = 1; lo = 0; end
            3'd3: begin hi = 2; lo = 0; end
            3'd1: begin hi = 2; lo = 1; end
            default: return 6'b000000;
        endcase
        if (d) begin t = hi; hi = lo; lo = t; end
        return (6'b100000 >> hi) | (6'b000100 >> lo);
    endfunction

    // Model: outputs drive once the synchronized Hall/dir have been legal and
    // unchanged with enable high for more than D consecutive clocks.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1 = 3'b000; m_s2 = 3'b000; m_ph = 3'b000; m_pd = 1'b0;
            m_flt = 1'b0; m_run = 0; m_edges = 0; m_g = 6'b0; m_pulse = 1'b0;
        end else begin
            m_hs = m_s2;
            m_s2 = m_s1;
            m_s1 = hall;
            if (!enable) begin
                m_run = 0; m_flt = 1'b0;
            end else if (m_flt) begin
                m_run = 0;
            end else if (m_hs == 3'b000 || m_hs == 3'b111) begin
                m_flt = 1'b1; m_run = 0;
            end else if (m_run > 0 && m_hs == m_ph && dir == m_pd) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_run = 1;
            end
            m_ph = m_hs;
            m_pd = dir;
            m_pulse = (m_run == D + 1);
            m_g = 6'b0;
            if (m_run >= D + 1) begin
                m_g = table_pat(m_hs, dir);
                if ((m_edges % 256) >= int'(duty)) m_g = m_g & 6'b000111;
            end
            m_edges++;
        end
        #1;
        check("model_gates", g, m_g);
        check("model_fault", fault, m_flt);
        check("model_comm_pulse", comm_pulse, m_pulse);
        check("shoot_through", int'(g[5:3] & g[2:0]), 0);
        if (comm_pulse) pulse_count++;
    end

    task automatic wait_off(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (g != 6'b0 && lat < 100);
    endtask

    task automatic count_off(output int z);
        z = 0;
        while (g == 6'b0 && z < 1000) begin
            z++;
            @(negedge clk);
        end
    endtask

    task automatic window(input logic [5:0] hm, input logic [5:0] lm,
                          output int nh, output int nl, output int no);
        nh = 0; nl = 0; no = 0;
        repeat (256) begin
            @(negedge clk);
            if ((g & hm) != 6'b0) nh++;
            if ((g & lm) != 6'b0) nl++;
            if ((g & ~(hm | lm)) != 6'b0) no++;
        end
    endtask

    initial begin
        int lat, z, nh, nl, no, p0;
        rst_n = 1'b0; enable = 1'b0; dir = 1'b0; duty = 8'd255; hall = 3'b101;
        repeat (3) @(negedge clk);
        check("reset_gates", g, 0);
        check("reset_fault", fault, 0);
        check("reset_pulse", comm_pulse, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_gates", g, 0);

        enable = 1'b1;
        @(negedge clk);
        count_off(z);
        check("startup_dead", z, 50);
        check("startup_pulse", comm_pulse, 1);
        check("startup_pattern", g & 6'b011111, 6'b000010);
        window(6'b100000, 6'b000010, nh, nl, no);
        check("startup_ha_on", nh, 255);
        check("startup_lb_on", nl, 256);
        check("startup_others", no, 0);

        duty = 8'd128;
        p0 = pulse_count;
        for (int i = 0; i < 6; i++) begin
            hall = steps[i];
            wait_off(lat);
            check("rot_latency", lat, 3);
            count_off(z);
            check("rot_dead", z, 50);
            check("rot_low", g & 6'b000111, exp_lo[i]);
            window(exp_hi[i], exp_lo[i], nh, nl, no);
            check("rot_hi_on", nh, 128);
            check("rot_lo_on", nl, 256);
            check("rot_others", no, 0);
        end
        check("rot_pulses", pulse_count - p0, 6);

        dir = 1'b1;
        wait_off(lat);
        check("dir_latency", lat, 1);
        count_off(z);
        check("dir_dead", z, 50);
        window(6'b010000, 6'b000100, nh, nl, no);
        check("rev_hb_on", nh, 128);
        check("rev_la_on", nl, 256);
        check("rev_others", no, 0);
        dir = 1'b0;
        wait_off(lat);
        check("dir_back_latency", lat, 1);
        count_off(z);
        check("dir_back_dead", z, 50);
        check("dir_back_low", g & 6'b000111, 6'b000010);

        hall = 3'b100;
        wait_off(lat);
        check("glitch_latency", lat, 3);
        repeat (19) @(negedge clk);
        hall = 3'b110;
        count_off(z);
        check("glitch_total_dead", 19 + z, 72);
        check("glitch_low", g & 6'b000111, 6'b000001);

        hall = 3'b111;
        wait_off(lat);
        check("illegal_latency", lat, 3);
        check("illegal_fault", fault, 1);
        hall = 3'b101;
        repeat (10) @(negedge clk);
        check("fault_latched", fault, 1);
        check("fault_gates", g, 0);
        enable = 1'b0;
        @(negedge clk);
        check("fault_clear", fault, 0);
        enable = 1'b1;
        @(negedge clk);
        count_off(z);
        check("restart_dead", z, 50);
        check("restart_low", g & 6'b000111, 6'b000010);

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        check("async_reset_gates", g, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_gates", g, 0);
        enable = 1'b1;
        @(negedge clk);
        count_off(z);
        check("post_reset_dead", z, 50);
        check("post_reset_pulse", comm_pulse, 1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
